conv_stream: RTL and testbench
==============================

Name: conv_stream

Overview:
- Streaming, clocked successor to the fully parallel convolution layer.
- Accepts one multi-channel pixel per beat in raster order and buffers K-1 rows in line buffers.
- Computes one output channel per valid KxK window, with configurable stride, right-shift scaling, optional ReLU and signed saturation.
- More output channels are built from more instances sharing the input stream.

Parameters:
- INPUT_SIZE, 32, square input frame edge in pixels.
- INPUT_CHANNELS, 3, channels per input pixel.
- KERNEL_SIZE, 3, square kernel edge K; K >= 1, K <= INPUT_SIZE.
- PX_SIZE, 8, bits per pixel channel and per kernel weight.
- STRIDE, 1, window step in both axes; STRIDE >= 1.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
- RELU, 0, 1 clamps negative results to 0.
- localparam OUTPUT_SIZE = (INPUT_SIZE-KERNEL_SIZE)/STRIDE + 1.
- localparam ACC_W = 2*PX_SIZE + clog2(K*K*INPUT_CHANNELS) + 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- kernel  in  K*K*INPUT_CHANNELS*PX_SIZE  signed weights, packed [ky][kx][ch][bit]. Captured on acceptance of pixel (0,0) of each frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_px  in  INPUT_CHANNELS*PX_SIZE  unsigned pixel, packed [ch][bit].
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output.
- out_px  out  PX_SIZE  signed output pixel.
- out_last  out  1  marks the final output of a frame.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_px=0, out_last=0.
  - Row/column counters=0.
  - Captured kernel=0.
  - Line-buffer contents are don't-care; they are fully rewritten before use.
- in_ready = !out_valid || out_ready. This gives a single output register with no skid buffer.
- A beat is accepted when in_valid && in_ready.
- Each accepted pixel:
  - is written at column col of the line buffer;
  - shifts the KxK window;
  - advances col. When col reaches INPUT_SIZE-1 it wraps to 0 and row increments.
  - At (INPUT_SIZE-1, INPUT_SIZE-1) both counters wrap to 0 and the next frame begins with no idle cycle.
- Window emission:
  - The pixel at (row,col) completes window top-left (r,c) = (row-K+1, col-K+1).
  - A window is emitted iff row >= K-1, col >= K-1, r%STRIDE==0 and c%STRIDE==0.
  - Windows never straddle rows (no padding, no wrap-around windows).
- Latency: out_valid rises the cycle after the completing pixel is accepted. out_px is held stable while out_valid && !out_ready.
- Output register:
  - With no emission and out_ready=1, out_valid clears.
  - Emission and drain in the same cycle: the new result replaces the old one and out_valid stays 1.
- Arithmetic, computed in ACC_W signed bits:
  - acc = sum over ky,kx,ch of ($unsigned px zero-extended) * ($signed weight).
  - res = acc >>> SHIFT.
  - If RELU=1 and res < 0, then res = 0.
  - Saturate res to [-(2^(PX_SIZE-1)), 2^(PX_SIZE-1)-1].
- out_last=1 with the output whose window is (r,c) = ((OUTPUT_SIZE-1)*STRIDE, (OUTPUT_SIZE-1)*STRIDE).
- Pixels after the last emitting position are consumed but produce no output.
- Outputs per frame = OUTPUT_SIZE^2, emitted in raster order.
- Kernel may change between frames; mid-frame changes are ignored.
- Reset mid-frame: the in-flight output is discarded and the next accepted pixel is treated as (0,0).

Test Plan:
- INPUT_SIZE=4, K=3, C=1, P=8, STRIDE=1, all pixels 1, all weights 1 -> 4 outputs of 9; out_last on the 4th only; each out_valid one cycle after pixels 10, 11, 14, 15 (0-based raster index) are accepted.
- Same config, pixel value = raster index 0..15, centre-only kernel (w[1][1]=1) -> outputs 5, 6, 9, 10. A second back-to-back frame gives identical results with no idle cycle.
- INPUT_SIZE=5, K=3, STRIDE=2, all pixels 10, weights 1 -> OUTPUT_SIZE=2; 4 outputs of 90, emitted after pixels 12, 14, 22, 24.
- Saturation, C=3, pixels 255, weights 1, SHIFT=4 -> acc=6885, res=430 -> out_px=127. Weights -1 with RELU=0 -> -128; with RELU=1 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_px unchanged, no pixel lost. On release, the outputs sequence matches the no-stall run.
- Assert rst after 7 pixels of a frame, then send a full 4x4 frame -> exactly 4 correct outputs; out_valid=0 during reset.

Source files
------------

// File: rtl/conv_stream.sv
// conv_stream: streaming KxK convolution producing one output channel.
//
// Pixels arrive one per beat in raster order. K-1 previous rows are kept in
// line buffers so that each accepted pixel supplies a full column to a KxK
// window shift register. When the pixel completes a window on the stride
// grid, the window is multiplied against the captured kernel. The sum is
// scaled by an arithmetic right shift, optionally clamped by ReLU, saturated
// to PX_SIZE signed bits and placed in a single output register.
// Additional output channels are built by instantiating more blocks on the
// same input stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   kernel     signed weights packed [ky][kx][ch][bit]; captured when pixel
//              (0,0) of a frame is accepted
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel (!out_valid || out_ready)
//   in_px      unsigned pixel packed [ch][bit]
//   out_valid  output pixel valid
//   out_ready  downstream accepts the output
//   out_px     signed output pixel
//   out_last   final output of a frame
module conv_stream #(
  parameter int INPUT_SIZE     = 32,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  parameter int STRIDE         = 1,
  parameter int SHIFT          = 0,
  parameter int RELU           = 0
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS*PX_SIZE-1:0] kernel,
  input  logic                                                      in_valid,
  output logic                                                      in_ready,
  input  logic [INPUT_CHANNELS*PX_SIZE-1:0]                         in_px,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic signed [PX_SIZE-1:0]                                 out_px,
  output logic                                                      out_last
);

  localparam int K           = KERNEL_SIZE;
  localparam int C           = INPUT_CHANNELS;
  localparam int PXW         = C * PX_SIZE;
  localparam int KW          = K * K * C * PX_SIZE;
  localparam int OUTPUT_SIZE = (INPUT_SIZE - K) / STRIDE + 1;
  localparam int ACC_W       = 2 * PX_SIZE + $clog2(K * K * C) + 1;
  localparam int CNT_W       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int LB_ROWS     = (K > 1) ? K - 1 : 1;
  localparam int LAST_POS    = (OUTPUT_SIZE - 1) * STRIDE;

  localparam logic [CNT_W-1:0] EDGE_MAX = CNT_W'(INPUT_SIZE - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - PX_SIZE + 1){1'b0}}, {(PX_SIZE - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - PX_SIZE + 1){1'b1}}, {(PX_SIZE - 1){1'b0}}};

  // Arithmetic shift scaling followed by the optional ReLU clamp.
  function automatic logic signed [ACC_W-1:0] scale_relu(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] r;
    r = a >>> SHIFT;
    if ((RELU != 0) && r[ACC_W-1]) r = '0;
    return r;
  endfunction

  // Signed saturation from the accumulator width down to PX_SIZE bits.
  function automatic logic signed [PX_SIZE-1:0] saturate(
    input logic signed [ACC_W-1:0] a
  );
    if (a > SAT_MAX)      return SAT_MAX[PX_SIZE-1:0];
    else if (a < SAT_MIN) return SAT_MIN[PX_SIZE-1:0];
    else                  return a[PX_SIZE-1:0];
  endfunction

  // Control state: frame position and captured kernel.
  logic [CNT_W-1:0] row_p0;
  logic [CNT_W-1:0] col_p0;
  logic [KW-1:0]    kern_p0;

  // Data state: line buffers (lb_p0[0] is the most recent previous row)
  // and the KxK window (win_p0[K-1] is the current row, [*][K-1] newest).
  logic [PXW-1:0] lb_p0  [LB_ROWS][INPUT_SIZE];
  logic [PXW-1:0] win_p0 [K][K];

  logic [PXW-1:0] col_vec [K];
  logic [PXW-1:0] win_nxt [K][K];
  logic [KW-1:0]  kern_use;

  logic accept;
  logic first_px;
  logic emit;
  logic emit_last;
  int   r_i;
  int   c_i;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pe;
  logic signed [ACC_W-1:0] we;

  logic                      vld_p1;
  logic                      last_p1;
  logic signed [PX_SIZE-1:0] px_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign first_px = (row_p0 == '0) && (col_p0 == '0);

  // Pixel (0,0) may itself complete a window when K=1, so the incoming
  // kernel is used directly on that beat.
  assign kern_use = first_px ? kernel : kern_p0;

  assign out_valid = vld_p1;
  assign out_px    = px_p1;
  assign out_last  = last_p1;

  // ---- p0: column gather and window shift ----
  always_comb begin
    for (int ky = 0; ky < K; ky++) col_vec[ky] = '0;
    col_vec[K-1] = in_px;
    for (int j = 0; j < K - 1; j++) col_vec[K-2-j] = lb_p0[j][col_p0];
  end

  always_comb begin
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K - 1; kx++) win_nxt[ky][kx] = win_p0[ky][kx+1];
      win_nxt[ky][K-1] = col_vec[ky];
    end
  end

  // Window (r,c) completed by this pixel; only windows fully inside the
  // current rows and on the stride grid are emitted.
  always_comb begin
    r_i       = int'(row_p0) - (K - 1);
    c_i       = int'(col_p0) - (K - 1);
    emit      = (r_i >= 0) && (c_i >= 0) &&
                ((r_i % STRIDE) == 0) && ((c_i % STRIDE) == 0);
    emit_last = (r_i == LAST_POS) && (c_i == LAST_POS);
  end

  always_comb begin
    acc = '0;
    pe  = '0;
    we  = '0;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        for (int ch = 0; ch < C; ch++) begin
          pe  = ACC_W'($signed({1'b0, win_nxt[ky][kx][ch*PX_SIZE +: PX_SIZE]}));
          we  = ACC_W'($signed(kern_use[((ky*K + kx)*C + ch)*PX_SIZE +: PX_SIZE]));
          acc = acc + pe * we;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0  <= '0;
      col_p0  <= '0;
      kern_p0 <= '0;
    end else if (accept) begin
      if (first_px) kern_p0 <= kernel;
      if (col_p0 == EDGE_MAX) begin
        col_p0 <= '0;
        if (row_p0 == EDGE_MAX) row_p0 <= '0;
        else                    row_p0 <= row_p0 + CNT_W'(1);
      end else begin
        col_p0 <= col_p0 + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          win_p0[ky][kx] <= win_nxt[ky][kx];
      if (K > 1) begin
        lb_p0[0][col_p0] <= in_px;
        for (int j = 1; j < K - 1; j++) lb_p0[j][col_p0] <= lb_p0[j-1][col_p0];
      end
    end
  end

  // ---- p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      px_p1   <= '0;
    end else if (accept && emit) begin
      vld_p1  <= 1'b1;
      last_p1 <= emit_last;
      px_p1   <= saturate(scale_relu(acc));
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream. Four instances cover the 4x4 stride-1,
// 5x5 stride-2 and 3-channel saturation (ReLU off/on) configurations.
`timescale 1ns/1ps
module tb_conv_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int px;
    int last;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];
  exp_t ea, eb, ec, ed;

  // A: 4x4, K=3, C=1, stride 1
  logic [71:0]       a_kernel;
  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]        a_in_px;
  logic signed [7:0] a_out_px;
  // B: 5x5, K=3, C=1, stride 2
  logic [71:0]       b_kernel;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]        b_in_px;
  logic signed [7:0] b_out_px;
  // C/D: 3x3, K=3, C=3, SHIFT=4; D has ReLU. Shared input stream.
  logic [215:0]      cd_kernel;
  logic              cd_in_valid, cd_out_ready;
  logic [23:0]       cd_in_px;
  logic              c_in_ready, c_out_valid, c_out_last;
  logic              d_in_ready, d_out_valid, d_out_last;
  logic signed [7:0] c_out_px, d_out_px;

  conv_stream #(.INPUT_SIZE(4), .INPUT_CHANNELS(1), .KERNEL_SIZE(3), .PX_SIZE(8),
                .STRIDE(1), .SHIFT(0), .RELU(0)) dut_a (
    .clk(clk), .rst(rst), .kernel(a_kernel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_px(a_in_px), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_px(a_out_px), .out_last(a_out_last));

  conv_stream #(.INPUT_SIZE(5), .INPUT_CHANNELS(1), .KERNEL_SIZE(3), .PX_SIZE(8),
                .STRIDE(2), .SHIFT(0), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .kernel(b_kernel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_px(b_in_px), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_px(b_out_px), .out_last(b_out_last));

  conv_stream #(.INPUT_SIZE(3), .INPUT_CHANNELS(3), .KERNEL_SIZE(3), .PX_SIZE(8),
                .STRIDE(1), .SHIFT(4), .RELU(0)) dut_c (
    .clk(clk), .rst(rst), .kernel(cd_kernel), .in_valid(cd_in_valid),
    .in_ready(c_in_ready), .in_px(cd_in_px), .out_valid(c_out_valid),
    .out_ready(cd_out_ready), .out_px(c_out_px), .out_last(c_out_last));

  conv_stream #(.INPUT_SIZE(3), .INPUT_CHANNELS(3), .KERNEL_SIZE(3), .PX_SIZE(8),
                .STRIDE(1), .SHIFT(4), .RELU(1)) dut_d (
    .clk(clk), .rst(rst), .kernel(cd_kernel), .in_valid(cd_in_valid),
    .in_ready(d_in_ready), .in_px(cd_in_px), .out_valid(d_out_valid),
    .out_ready(cd_out_ready), .out_px(d_out_px), .out_last(d_out_last));

  localparam logic [215:0] K_ONES9  = {144'h0, {9{8'h01}}};
  localparam logic [215:0] K_CENTRE = {144'h0, 72'h01 << 32};
  localparam logic [215:0] K_POS27  = {27{8'h01}};
  localparam logic [215:0] K_NEG27  = {27{8'hFF}};

  int exp_ctr [4] = '{5, 6, 9, 10};
  int cd_px   [4] = '{255, 255, 16, 16};
  int cd_neg  [4] = '{0, 1, 0, 1};
  int cd_expc [4] = '{127, -128, 27, -27};
  int cd_expd [4] = '{127, 0, 27, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e, input int px, input int last);
    chk({nm, "_px"}, px, e.px);
    chk({nm, "_last"}, last, e.last);
    if (e.cyc >= 0) chk({nm, "_latency"}, cyc, e.cyc);
  endtask

  // One beat on the chosen stream; called at posedge+1, returns at posedge+1.
  task automatic beat(input int dut, input logic [23:0] px, input logic [215:0] kern,
                      input bit emit, input int e0, input int e1, input bit last,
                      input bit timed);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    case (dut)
      0:       begin a_in_valid = 1'b1; a_in_px = px[7:0]; a_kernel = kern[71:0]; end
      1:       begin b_in_valid = 1'b1; b_in_px = px[7:0]; b_kernel = kern[71:0]; end
      default: begin cd_in_valid = 1'b1; cd_in_px = px; cd_kernel = kern; end
    endcase
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      case (dut)
        0:       ok = a_in_ready;
        1:       ok = b_in_ready;
        default: ok = c_in_ready && d_in_ready;
      endcase
    end
    chk("accept", int'(ok), 1);
    if (ok && emit) begin
      e.px   = e0;
      e.last = int'(last);
      e.cyc  = timed ? cyc + 1 : -1;
      case (dut)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: begin
          qc.push_back(e);
          e.px = e1;
          qd.push_back(e);
        end
      endcase
    end
    @(posedge clk);
    #1;
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    cd_in_valid = 1'b0;
  endtask

  function automatic bit emit_a(input int i);
    return (i == 10) || (i == 11) || (i == 14) || (i == 15);
  endfunction

  // Full 4x4 frame on A. idx_px: pixel = raster index with expected
  // centre-tap results; otherwise all ones giving 9 per window.
  task automatic frame_a(input bit idx_px, input logic [215:0] kern,
                         input logic [215:0] kern_late, input bit timed);
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      beat(0, idx_px ? 24'(i) : 24'd1, (i >= 3) ? kern_late : kern, emit_a(i),
           idx_px ? exp_ctr[k] : 9, 0, i == 15, timed);
      if (emit_a(i)) k++;
    end
  endtask

  // Monitors: compare on every transfer; while stalled, the held value must
  // already be the next expected output and input must be blocked.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        chk("a_expected_pending", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          cmp_out("a", ea, int'(a_out_px), int'(a_out_last));
        end
      end else if (a_out_valid) begin
        chk("a_stall_in_ready", int'(a_in_ready), 0);
        if (qa.size() > 0) chk("a_stall_px_hold", int'(a_out_px), qa[0].px);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      chk("b_expected_pending", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        cmp_out("b", eb, int'(b_out_px), int'(b_out_last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && c_out_valid && cd_out_ready) begin
      chk("c_expected_pending", int'(qc.size() > 0), 1);
      if (qc.size() > 0) begin
        ec = qc.pop_front();
        cmp_out("c", ec, int'(c_out_px), int'(c_out_last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d_out_valid && cd_out_ready) begin
      chk("d_expected_pending", int'(qd.size() > 0), 1);
      if (qd.size() > 0) begin
        ed = qd.pop_front();
        cmp_out("d", ed, int'(d_out_px), int'(d_out_last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    a_kernel     = '0; a_in_valid  = 1'b0; a_in_px  = '0; a_out_ready  = 1'b1;
    b_kernel     = '0; b_in_valid  = 1'b0; b_in_px  = '0; b_out_ready  = 1'b1;
    cd_kernel    = '0; cd_in_valid = 1'b0; cd_in_px = '0; cd_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", int'(a_out_valid), 0);
    chk("rst_a_px",    int'(a_out_px),    0);
    chk("rst_a_last",  int'(a_out_last),  0);
    chk("rst_b_valid", int'(b_out_valid), 0);
    chk("rst_c_valid", int'(c_out_valid), 0);
    chk("rst_c_px",    int'(c_out_px),    0);
    chk("rst_d_valid", int'(d_out_valid), 0);
    chk("rst_d_last",  int'(d_out_last),  0);
    chk("rst_a_ready", int'(a_in_ready),  1);
    @(posedge clk);
    #1 rst = 1'b0;

    // All ones: four windows of 9, then two back-to-back raster-index frames
    // with a centre tap; the mid-frame kernel change must be ignored.
    frame_a(1'b0, K_ONES9, K_ONES9, 1'b1);
    frame_a(1'b1, K_CENTRE, K_ONES9, 1'b1);
    frame_a(1'b1, K_CENTRE, K_CENTRE, 1'b1);

    // Stride 2 on 5x5.
    for (int i = 0; i < 25; i++)
      beat(1, 24'd10, K_ONES9, (i == 12) || (i == 14) || (i == 22) || (i == 24),
           90, 0, i == 24, 1'b1);

    // Shift, saturation and ReLU; one output per 3x3 frame.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 9; i++)
        beat(2, {3{8'(cd_px[f])}}, cd_neg[f] ? K_NEG27 : K_POS27, i == 8,
             cd_expc[f], cd_expd[f], 1'b1, 1'b1);

    // Backpressure: stall the second output for 5 cycles.
    fork
      frame_a(1'b1, K_CENTRE, K_CENTRE, 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (a_out_valid) seen = 1'b1;
        end
        chk("stall_first_output_seen", int'(seen), 1);
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset after 7 pixels, then a full frame.
    for (int i = 0; i < 7; i++) beat(0, 24'(50 + i), K_ONES9, 1'b0, 0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_valid", int'(a_out_valid), 0);
    chk("midrst_a_last",  int'(a_out_last),  0);
    @(posedge clk);
    #1 rst = 1'b0;
    frame_a(1'b1, K_CENTRE, K_CENTRE, 1'b1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);
    chk("qd_drained", qd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
